mux16_rr_arbiter: RTL and testbench
===================================

# mux16_rr_arbiter

Round-robin arbiter that shares one `mux16` datapath among 16 requesters. Each cycle it picks one requester, steers the `mux16` select to it, and captures the selected word into a registered output stage with a valid/ready handshake. Optional locked bursts let one requester hold the datapath for up to `MAX_BURST` consecutive beats. It sits between 16 producer blocks and a single downstream consumer.

## Interface
- `N`, 8: data width per requester; passed to the internal `mux16`.
- `MAX_BURST`, 4: maximum beats per locked burst; 1 disables locking.
- `clk`  input  1  system clock, rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `req`  input  16  `req[i]` = requester i has a word; held until acked.
- `lock`  input  16  `lock[i]` = more beats follow the current one from requester i; sampled with the beat.
- `data_in`  input  16*N  packed words; requester i at `[i*N +: N]`; drives `mux16` `in0..in15`.
- `ack`  output  16  one-hot, combinational; `ack[i]` = word i accepted this cycle.
- `out_valid`  output  1  `out_data` holds a word.
- `out_ready`  input  1  consumer accepts when `out_valid & out_ready`.
- `out_data`  output  N  registered selected word.
- `out_src`  output  4  index of the requester that produced `out_data`.

## Operation
- Internal state: `ptr[3:0]` (priority start), `state` ∈ {IDLE, LOCKED}, `owner[3:0]`, `cnt` (width `$clog2(MAX_BURST+1)`).
- `can_load = !out_valid | out_ready`. No beat is granted unless `can_load`.
- Winner index drives `mux16` `switch`; the `mux16` output is loaded into `out_data`.
- IDLE, `can_load` and `|req`: winner = first set bit of `req` scanning ptr, ptr+1, … with wrap mod 16.
  - Assert `ack[winner]`, load `out_data`/`out_src`, set `out_valid`, `ptr <= winner+1` (15 wraps to 0).
  - If `lock[winner]` and `MAX_BURST>1`: go LOCKED, `owner <= winner`, `cnt <= 1`.
- LOCKED: only `owner` is eligible; other requests are ignored.
  - `can_load & req[owner]`: ack owner, load, `cnt <= cnt+1`. Return to IDLE if `!lock[owner]` or `cnt+1 == MAX_BURST`.
  - `can_load & !req[owner]`: return to IDLE with no beat that cycle (one bubble).
  - `!can_load`: hold everything.
- `ptr` is always owner+1 after any beat, so the next IDLE arbitration starts after the last owner.
- Drain without refill (`out_valid & out_ready` with no grant) clears `out_valid`.
- Simultaneous drain and grant: `out_valid` stays 1 and the new word replaces the old one.

## Timing
- Reset values, applied asynchronously on `rst_n` low:
  - `out_valid` 0, `out_data` 0, `out_src` 0.
  - `ptr` 0, `state` IDLE, `owner` 0, `cnt` 0.
  - `ack` is 0 while reset is held.
- `ack` is combinational from `req`, `lock`, state, `out_valid` and `out_ready`, in the same cycle as the load edge.
- Latency: a word acked in cycle t appears on `out_data` with `out_valid` in cycle t+1.
- Throughput: 1 beat/cycle with `out_ready` held high.
- Requesters must keep `data_in` slice and `req` stable until acked. `ack` never asserts for a requester whose `req` is 0.
- Deasserting `rst_n` mid-burst drops the burst. The first arbitration after reset starts at index 0.

## Test plan
- Reset: `rst_n`=0 with `req`=16'hFFFF → `out_valid`=0, `out_data`=0, `ack`=0. First cycle after release acks requester 0.
- Fairness: `req`=16'h0005, no lock, `out_ready`=1 → acks go 0,2,0,2…; `out_src` follows one cycle later; data matches slices.
- Wrap: ptr=15 (after a grant to 14), `req`=16'h8001 → ack 15, then 0, then 15.
- Backpressure: `out_valid`=1, `out_ready`=0 for 3 cycles, `req`=16'h0010 → `ack`=0 and `out_data` stable. The cycle `out_ready` rises, `ack[4]`=1 and the new word follows next cycle with no bubble.
- Burst cap: `MAX_BURST`=4, `req`=16'h0003, `lock`=16'h0001 held → ack sequence 0,0,0,0,1,0,0,0,0,1.
- Burst abort: in LOCKED, owner drops `req` → one idle cycle, then IDLE arbitration from owner+1. Separately, `rst_n` pulsed low mid-burst → `out_valid` goes 0 immediately and the next ack is the lowest set index.

Source files
------------

// File: rtl/mux16_rr_arbiter.sv
// mux16_rr_arbiter: round-robin arbiter steering one shared mux16 datapath into a registered valid/ready output stage
// Ports:
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req[15:0]             per-requester word-available flags, held until acked
//   lock[15:0]            per-requester "more beats follow" flag, sampled with the beat
//   data_in[16*N-1:0]     packed requester words, requester i at [i*N +: N]
//   ack[15:0]             one-hot combinational accept strobe
//   out_valid/out_ready   output handshake
//   out_data[N-1:0]       registered selected word
//   out_src[3:0]          requester index that produced out_data

module mux16 #(
    parameter int N = 8
) (
    input  logic [N-1:0] in0,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic [N-1:0] in3,
    input  logic [N-1:0] in4,
    input  logic [N-1:0] in5,
    input  logic [N-1:0] in6,
    input  logic [N-1:0] in7,
    input  logic [N-1:0] in8,
    input  logic [N-1:0] in9,
    input  logic [N-1:0] in10,
    input  logic [N-1:0] in11,
    input  logic [N-1:0] in12,
    input  logic [N-1:0] in13,
    input  logic [N-1:0] in14,
    input  logic [N-1:0] in15,
    input  logic [3:0]   switch,
    output logic [N-1:0] out
);
    logic [N-1:0] w [16];
    assign w = '{in0, in1, in2, in3, in4, in5, in6, in7, in8, in9, in10, in11, in12, in13, in14, in15};
    assign out = w[switch];
endmodule

module mux16_rr_arbiter #(
    parameter int N         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [15:0]     req,
    input  logic [15:0]     lock,
    input  logic [16*N-1:0] data_in,
    output logic [15:0]     ack,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    out_data,
    output logic [3:0]      out_src
);
    localparam int CW = $clog2(MAX_BURST + 1);
    typedef enum logic {IDLE, LOCKED} state_t;
    state_t        state, state_d;
    logic [3:0]    ptr, owner, owner_d, win;
    logic [CW-1:0] cnt, cnt_d;
    logic          can_load, grant, found;
    logic [N-1:0]  mux_out;
    assign can_load = !out_valid || out_ready;
    always_comb begin
        logic [3:0] idx;
        idx = '0;
        win = owner;
        found = 1'b0;
        if (state == IDLE)
            for (int k = 0; k < 16; k++) begin
                idx = ptr + 4'(k);
                if (!found && req[idx]) begin
                    win = idx;
                    found = 1'b1;
                end
            end
        // ack must stay low while reset is held, so the grant is gated by rst_n
        grant = rst_n && can_load && (state == IDLE ? found : req[owner]);
        state_d = state;
        owner_d = owner;
        cnt_d = cnt;
        if (state == IDLE) begin
            if (grant && lock[win] && MAX_BURST > 1) begin
                state_d = LOCKED;
                owner_d = win;
                cnt_d = CW'(1);
            end
        end else if (can_load) begin
            // a missing owner request ends the burst with a bubble; cnt_d is then irrelevant
            cnt_d = cnt + 1'b1;
            state_d = (!req[owner] || !lock[owner] || cnt_d == CW'(MAX_BURST)) ? IDLE : LOCKED;
        end
        ack = grant ? 16'(1) << win : '0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr <= '0;
            owner <= '0;
            cnt <= '0;
            out_valid <= 1'b0;
            out_data <= '0;
            out_src <= '0;
        end else begin
            state <= state_d;
            owner <= owner_d;
            cnt <= cnt_d;
            out_valid <= grant || (out_valid && !out_ready);
            if (grant) begin
                ptr <= win + 4'd1;
                out_data <= mux_out;
                out_src <= win;
            end
        end
    end
    mux16 #(.N(N)) u_mux (
        .in0   (data_in[0*N +: N]),
        .in1   (data_in[1*N +: N]),
        .in2   (data_in[2*N +: N]),
        .in3   (data_in[3*N +: N]),
        .in4   (data_in[4*N +: N]),
        .in5   (data_in[5*N +: N]),
        .in6   (data_in[6*N +: N]),
        .in7   (data_in[7*N +: N]),
        .in8   (data_in[8*N +: N]),
        .in9   (data_in[9*N +: N]),
        .in10  (data_in[10*N +: N]),
        .in11  (data_in[11*N +: N]),
        .in12  (data_in[12*N +: N]),
        .in13  (data_in[13*N +: N]),
        .in14  (data_in[14*N +: N]),
        .in15  (data_in[15*N +: N]),
        .switch(win),
        .out   (mux_out)
    );
endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// tb_mux16_rr_arbiter: directed and randomized checks of mux16_rr_arbiter against a behavioural model
module tb_mux16_rr_arbiter;
    localparam int N  = 8;
    localparam int MB = 4;
    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [15:0]     req = '0;
    logic [15:0]     lock = '0;
    logic [16*N-1:0] data_in = '0;
    logic            out_ready = 1'b1;
    logic [15:0]     ack;
    logic            out_valid;
    logic [N-1:0]    out_data;
    logic [3:0]      out_src;
    int checks = 0;
    int passed = 0;
    int m_ptr, m_owner, m_beats;
    logic m_valid;
    logic [N-1:0] m_data;
    logic [3:0] m_src;
    logic [15:0] last_ack;

    mux16_rr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .lock(lock), .data_in(data_in),
        .ack(ack), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_src(out_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        m_ptr = 0;
        m_owner = -1;
        m_beats = 0;
        m_valid = 1'b0;
        m_data = '0;
        m_src = '0;
    endtask

    function automatic int model_win();
        if (!rst_n || !(!m_valid || out_ready)) return -1;
        if (m_owner >= 0) return req[m_owner] ? m_owner : -1;
        for (int k = 0; k < 16; k++)
            if (req[(m_ptr + k) % 16]) return (m_ptr + k) % 16;
        return -1;
    endfunction

    task automatic model_step(input int w);
        bit can;
        can = !m_valid || out_ready;
        if (w >= 0) begin
            m_data = data_in[w*N +: N];
            m_src = 4'(w);
            m_valid = 1'b1;
            m_ptr = (w + 1) % 16;
            if (m_owner >= 0) begin
                m_beats++;
                if (!lock[w] || m_beats == MB) m_owner = -1;
            end else if (lock[w] && MB > 1) begin
                m_owner = w;
                m_beats = 1;
            end
        end else begin
            if (m_owner >= 0 && can) m_owner = -1;
            if (m_valid && out_ready) m_valid = 1'b0;
        end
    endtask

    // exp_idx: -2 = model only, -1 = no ack expected, else the requester that must be acked
    task automatic cycle(input int exp_idx);
        int w;
        #3;
        w = model_win();
        last_ack = ack;
        chk("ack", 32'(ack), w < 0 ? 32'h0 : 32'h1 << w);
        if (exp_idx != -2) chk("ack_directed", 32'(ack), exp_idx < 0 ? 32'h0 : 32'h1 << exp_idx);
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data", 32'(out_data), 32'(m_data));
        chk("out_src", 32'(out_src), 32'(m_src));
        @(posedge clk);
        if (rst_n) model_step(w);
        #1;
    endtask

    initial begin
        model_reset();
        data_in = {$urandom, $urandom, $urandom, $urandom};
        req = 16'hFFFF;
        @(posedge clk);
        #1;
        cycle(-1);
        rst_n = 1'b1;
        cycle(0);
        req = '0;
        cycle(-1);
        req = 16'h0005;
        cycle(2); cycle(0); cycle(2); cycle(0);
        req = 16'h4000;
        cycle(14);
        req = 16'h8001;
        cycle(15); cycle(0); cycle(15);
        req = 16'h0010;
        out_ready = 1'b0;
        cycle(-1); cycle(-1); cycle(-1);
        out_ready = 1'b1;
        cycle(4);
        req = '0;
        cycle(-1);
        req = 16'h0003;
        lock = 16'h0001;
        cycle(0); cycle(0); cycle(0); cycle(0); cycle(1);
        cycle(0); cycle(0); cycle(0); cycle(0); cycle(1);
        cycle(0);
        req = 16'h0002;
        cycle(-1);
        cycle(1);
        req = '0;
        cycle(-1);
        req = 16'h0009;
        lock = 16'h0008;
        cycle(3);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("valid_async_reset", 32'(out_valid), 32'h0);
        chk("ack_in_reset", 32'(ack), 32'h0);
        cycle(-1);
        rst_n = 1'b1;
        cycle(0);
        req = '0;
        lock = '0;
        cycle(-1);
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < 16; i++)
                if (last_ack[i] || !req[i]) begin
                    req[i] = $urandom_range(0, 2) != 0;
                    data_in[i*N +: N] = N'($urandom);
                end
            lock = 16'($urandom) | 16'($urandom);
            out_ready = $urandom_range(0, 3) != 0;
            cycle(-2);
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
